// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared types for the APB command queue.
//   APB_AW / APB_DW : address / data widths that size cmd_t
//   cmd_t           : one queued host command {write, addr, wdata, strb, prot}
//   state_e         : issue FSM states {IDLE, ISSUE, WAIT, RESP}
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
    logic [3:0]        strb;
    logic [2:0]        prot;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/apb_cmd_fifo.sv
// -----------------------------------------------------------------------------
// apb_cmd_fifo
// Synchronous FIFO of cmd_t with a registered read port (block-RAM style).
// The head entry appears on dout the cycle after pop is asserted.
// Ports:
//   clk, srst   clock, synchronous active-high reset (empties the FIFO)
//   push, din   write din when push and not full
//   pop, dout   read the head into dout when pop and not empty
//   full, empty status from the registered pointers only, so a pop does
//               not free a slot for a push in the same cycle
// -----------------------------------------------------------------------------
module apb_cmd_fifo
  import apb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output logic full,
  output logic empty,
  output cmd_t dout
);

  localparam int PTR_W = $clog2(DEPTH);

  cmd_t             r_mem [DEPTH];
  cmd_t             r_dout;
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra wrap bit: equal pointers = empty, only the wrap bit differing = full.
  assign full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                 (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_dout;

  // Storage is left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_dout   <= r_mem[r_rd_ptr[PTR_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/apb_cmd_queue.sv
// -----------------------------------------------------------------------------
// apb_cmd_queue
// Buffers host APB commands, issues them one at a time to the APB master
// wrapper (transfer pulse + S* fields), watches the bus for completion and
// returns one response per command, strictly in order.
// Ports:
//   PCLK, PRESET                clock, synchronous active-high reset
//   cmd_valid/cmd_ready + cmd_* host command channel
//   transfer, S*                start pulse and command fields to the master
//   PSEL/PENABLE/PREADY/PSLVERR bus monitor taps, PRDATA read data
//   rsp_valid/rsp_ready + rsp_* response channel (rdata, err, write echo)
// Parameters: DEPTH (power of 2, >=2), AW/DW (must equal the package widths
// that size cmd_t), TIMEOUT.
// Optional feature: define APB_TIMEOUT_EN to force an error response after
// TIMEOUT cycles in WAIT without completion.
// -----------------------------------------------------------------------------
module apb_cmd_queue
  import apb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW,
  parameter int TIMEOUT = 64
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [3:0]    cmd_strb,
  input  logic [2:0]    cmd_prot,
  output logic          transfer,
  output logic          SWRITE,
  output logic [AW-1:0] SADDR,
  output logic [DW-1:0] SWDATA,
  output logic [3:0]    SSTRB,
  output logic [2:0]    SPROT,
  input  logic          PSEL,
  input  logic          PENABLE,
  input  logic          PREADY,
  input  logic          PSLVERR,
  input  logic [DW-1:0] PRDATA,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_write
);

  state_e          r_state, w_state_next;
  cmd_t            r_hold, w_hold_next;
  logic            r_transfer, w_transfer_next;
  logic            r_rsp_valid, w_rsp_valid_next;
  logic [DW-1:0]   r_rsp_rdata, w_rsp_rdata_next;
  logic            r_rsp_err, w_rsp_err_next;
  logic            r_rsp_write, w_rsp_write_next;

  cmd_t            w_cmd_in;
  cmd_t            w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_complete;

  assign w_cmd_in = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata,
                      strb: cmd_strb, prot: cmd_prot};

  apb_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (PCLK),
    .srst  (PRESET),
    .push  (cmd_valid),
    .din   (w_cmd_in),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .dout  (w_head)
  );

  assign w_complete = PSEL && PENABLE && PREADY;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Counter value at which the next WAIT cycle brings it to TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

  always_comb begin
    w_state_next     = r_state;
    w_hold_next      = r_hold;
    w_transfer_next  = 1'b0;
    w_rsp_valid_next = r_rsp_valid;
    w_rsp_rdata_next = r_rsp_rdata;
    w_rsp_err_next   = r_rsp_err;
    w_rsp_write_next = r_rsp_write;
    w_pop            = 1'b0;
`ifdef APB_TIMEOUT_EN
    w_cnt_next       = r_cnt;
`endif
    unique case (r_state)
      IDLE: begin
        // The FIFO read is registered: the head is on w_head during ISSUE.
        if (!w_empty && !r_rsp_valid) begin
          w_pop        = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        w_hold_next     = w_head;
        w_transfer_next = 1'b1;
        w_state_next    = WAIT;
`ifdef APB_TIMEOUT_EN
        w_cnt_next      = '0;
`endif
      end
      WAIT: begin
        // Completion is checked first so it wins over a simultaneous timeout.
        if (w_complete) begin
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = r_hold.write ? '0 : PRDATA;
          w_rsp_err_next   = PSLVERR;
          w_rsp_write_next = r_hold.write;
          w_state_next     = RESP;
        end
`ifdef APB_TIMEOUT_EN
        else if (r_cnt == CNT_LAST) begin
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = '0;
          w_rsp_err_next   = 1'b1;
          w_rsp_write_next = r_hold.write;
          w_state_next     = RESP;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_next = 1'b0;
          w_state_next     = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_transfer  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_write <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_hold      <= w_hold_next;
      r_transfer  <= w_transfer_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_rsp_err   <= w_rsp_err_next;
      r_rsp_write <= w_rsp_write_next;
`ifdef APB_TIMEOUT_EN
      r_cnt       <= w_cnt_next;
`endif
    end
  end

  assign cmd_ready = !w_full;
  assign transfer  = r_transfer;
  assign SWRITE    = r_hold.write;
  assign SADDR     = r_hold.addr;
  assign SWDATA    = r_hold.wdata;
  assign SSTRB     = r_hold.strb;
  assign SPROT     = r_hold.prot;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign rsp_write = r_rsp_write;

endmodule

// File: tb/tb_apb_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_apb_cmd_queue
// Scoreboard bench: pushes compute the expected issue fields and response from
// a memory-level model; a monitor pops and compares whenever the DUT issues a
// transfer or completes a response handshake. A behavioural APB master/slave
// reacts to transfer pulses.
// -----------------------------------------------------------------------------
module tb_apb_cmd_queue;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } cmd_s;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        write;
  } rsp_s;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        transfer, SWRITE;
  logic [31:0] SADDR, SWDATA;
  logic [3:0]  SSTRB;
  logic [2:0]  SPROT;
  logic        PSEL, PENABLE, PREADY, PSLVERR;
  logic [31:0] PRDATA;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_write;
  logic [31:0] rsp_rdata;

  apb_cmd_queue #(.DEPTH(DEPTH), .AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .transfer(transfer), .SWRITE(SWRITE), .SADDR(SADDR), .SWDATA(SWDATA),
    .SSTRB(SSTRB), .SPROT(SPROT),
    .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_write(rsp_write)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  cmd_s        exp_issue[$];
  rsp_s        exp_rsp[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];

  bit hold_ready = 0;
  int max_ws = 0;
  bit rand_ready = 0;
  bit expect_timeout = 0;
  int xfer_count = 0;
  int last_push_cyc = 0;
  int last_xfer_cyc = 0;
  int last_cmpl_cyc = 0;
  logic [31:0] addr_tab [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic bit slave_err(input logic [31:0] a);
    return a[11:8] == 4'hE;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Push one command; on acceptance record the expected issue and response.
  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p, input bit timeout_rsp);
    int t = 0;
    bit rdy;
    rsp_s r;
    logic [31:0] old;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    cmd_strb = s; cmd_prot = p;
    do begin
      @(negedge PCLK);
      rdy = cmd_ready;
      @(posedge PCLK);
      t++;
    end while (!rdy && t < 500);
    #1;
    cmd_valid = 1'b0;
    if (!rdy) begin
      check("push_accept", 0, 1);
      return;
    end
    last_push_cyc = cyc;
    exp_issue.push_back('{w, a, d, s, p});
    if (timeout_rsp) begin
      r = '{32'h0, 1'b1, w};
    end else if (w) begin
      if (!slave_err(a)) begin
        old = model_mem.exists(a) ? model_mem[a] : 32'h0;
        model_mem[a] = merge(old, d, s);
      end
      r = '{32'h0, slave_err(a), 1'b1};
    end else begin
      r = '{model_mem.exists(a) ? model_mem[a] : 32'h0, slave_err(a), 1'b0};
    end
    exp_rsp.push_back(r);
    $display("push %s addr=%h wdata=%h strb=%h at cycle %0d", w ? "WR" : "RD", a, d, s, cyc);
  endtask

  task automatic wait_xfer(input int n_before);
    int t = 0;
    while (xfer_count == n_before && t < 200) begin cycles(1); t++; end
    check("wait_transfer", xfer_count != n_before, 1);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_rsp.size() != 0 && t < 3000) begin @(posedge PCLK); t++; end
    #1;
    check({name, "_drain_rsp"}, exp_rsp.size(), 0);
    check({name, "_drain_issue"}, exp_issue.size(), 0);
  endtask

  // Behavioural APB master + slave driven by the transfer pulse.
  initial begin
    logic [31:0] sa, sd;
    logic        sw, serr;
    logic [3:0]  ss;
    int ws, n;
    PSEL = 0; PENABLE = 0; PREADY = 0; PSLVERR = 0; PRDATA = 0;
    forever begin
      @(posedge PCLK); #1;
      if (!PRESET && transfer) begin
        sa = SADDR; sw = SWRITE; sd = SWDATA; ss = SSTRB;
        serr = slave_err(sa);
        PSEL = 1'b1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        ws = $urandom_range(0, max_ws);
        n = 0;
        while ((hold_ready || n < ws) && !PRESET && n < 2000) begin
          @(posedge PCLK); #1;
          n++;
        end
        if (!PRESET) begin
          PREADY = 1'b1; PSLVERR = serr;
          PRDATA = sw ? $urandom : (slave_mem.exists(sa) ? slave_mem[sa] : 32'h0);
          @(posedge PCLK); #1;
          if (sw && !serr) slave_mem[sa] = merge(slave_mem.exists(sa) ? slave_mem[sa] : 32'h0, sd, ss);
        end
        PSEL = 0; PENABLE = 0; PREADY = 0; PSLVERR = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge PCLK); #1;
      if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic prev_xfer = 0;
    logic prev_rv = 0;
    cmd_s e;
    rsp_s r;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        prev_xfer = 0; prev_rv = 0;
        continue;
      end
      if (PSEL && PENABLE && PREADY) last_cmpl_cyc = cyc + 1;
      if (transfer) begin
        check("transfer_single_cycle", prev_xfer, 0);
        check("no_issue_while_rsp", rsp_valid, 0);
        xfer_count++;
        last_xfer_cyc = cyc;
        if (exp_issue.size() == 0) begin
          check("unexpected_transfer", 1, 0);
        end else begin
          e = exp_issue.pop_front();
          check("SWRITE", SWRITE, e.write);
          check("SADDR", SADDR, e.addr);
          check("SWDATA", SWDATA, e.wdata);
          check("SSTRB", SSTRB, e.strb);
          check("SPROT", SPROT, e.prot);
          $display("issue addr=%h write=%0b at cycle %0d", SADDR, SWRITE, cyc);
        end
      end
      if (rsp_valid && !prev_rv && !expect_timeout)
        check("rsp_after_completion", cyc, last_cmpl_cyc);
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          check("unexpected_response", 1, 0);
        end else begin
          r = exp_rsp.pop_front();
          check("rsp_rdata", rsp_rdata, r.rdata);
          check("rsp_err", rsp_err, r.err);
          check("rsp_write", rsp_write, r.write);
          $display("response rdata=%h err=%0b write=%0b at cycle %0d", rsp_rdata, rsp_err, rsp_write, cyc);
        end
      end
      prev_xfer = transfer;
      prev_rv = rsp_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t, t0;
    bit seen;
    addr_tab[0] = 32'h10; addr_tab[1] = 32'h14; addr_tab[2] = 32'h20;
    addr_tab[3] = 32'h24; addr_tab[4] = 32'hE10;
    PRESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    cmd_strb = 0; cmd_prot = 0; rsp_ready = 1;
    cycles(3);
    @(negedge PCLK);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_transfer", transfer, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_fields", {rsp_rdata, rsp_err, rsp_write}, 0);
    check("reset_s_fields", {SWRITE, SADDR, SWDATA, SSTRB, SPROT}, 0);
    @(posedge PCLK); #1;
    PRESET = 0;
    cycles(2);

    // Single write with zero wait states, latency checks.
    n = xfer_count;
    push(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0);
    t0 = last_push_cyc;
    wait_xfer(n);
    check("issue_latency", last_xfer_cyc - t0, 2);
    wait_drain("single_write");
    check("single_write_one_xfer", xfer_count - n, 1);

    // Write then read of the same address.
    push(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd1, 0);
    push(0, 32'h10, 32'h0, 4'h0, 3'd2, 0);
    wait_drain("write_read");

    // Five back-to-back commands while the first is stalled in WAIT.
    hold_ready = 1;
    n = xfer_count;
    push(1, 32'h30, 32'h11223344, 4'hF, 3'd0, 0);
    wait_xfer(n);
    push(0, 32'h30, 32'h0, 4'h0, 3'd0, 0);
    push(1, 32'h34, 32'hA5A5A5A5, 4'h3, 3'd5, 0);
    push(0, 32'h34, 32'h0, 4'h0, 3'd0, 0);
    push(1, 32'h30, 32'hCAFEF00D, 4'hC, 3'd7, 0);
    @(negedge PCLK);
    check("full_cmd_ready_low", cmd_ready, 0);
    fork
      begin cycles(5); hold_ready = 0; end
    join_none
    push(0, 32'h30, 32'h0, 4'h0, 3'd3, 0);
    wait_drain("back_to_back");

    // Response backpressure: rsp_ready low for 10 cycles.
    rsp_ready = 0;
    n = xfer_count;
    push(1, 32'h40, 32'h0BADF00D, 4'hF, 3'd0, 0);
    push(0, 32'h40, 32'h0, 4'h0, 3'd0, 0);
    t = 0;
    do begin @(negedge PCLK); t++; end while (!rsp_valid && t < 100);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge PCLK);
      check("stall_rsp_valid", rsp_valid, 1);
      if (exp_rsp.size() > 0) check("stall_rsp_fields", {rsp_rdata, rsp_err, rsp_write},
                                    {exp_rsp[0].rdata, exp_rsp[0].err, exp_rsp[0].write});
      check("stall_no_issue", xfer_count - n, 1);
    end
    @(posedge PCLK); #1;
    rsp_ready = 1;
    wait_drain("backpressure");
    check("stall_resume_issue", xfer_count - n, 2);

    // Randomized traffic with random wait states and response backpressure.
    max_ws = 3;
    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      push(1'($urandom_range(0, 1)), addr_tab[$urandom_range(0, 4)], $urandom,
           4'($urandom_range(1, 15)), 3'($urandom_range(0, 7)), 0);
      cycles($urandom_range(0, 3));
    end
    rand_ready = 0;
    cycles(1);
    rsp_ready = 1;
    wait_drain("random");
    max_ws = 0;

    // Reset in WAIT with three reads queued.
    hold_ready = 1;
    n = xfer_count;
    push(0, 32'h10, 32'h0, 4'h0, 3'd0, 0);
    wait_xfer(n);
    push(0, 32'h14, 32'h0, 4'h0, 3'd0, 0);
    push(0, 32'h20, 32'h0, 4'h0, 3'd0, 0);
    push(0, 32'h24, 32'h0, 4'h0, 3'd0, 0);
    PRESET = 1;
    @(negedge PCLK);
    check("midreset_transfer", transfer, 0);
    check("midreset_rsp_valid", rsp_valid, 0);
    check("midreset_cmd_ready", cmd_ready, 1);
    exp_issue.delete();
    exp_rsp.delete();
    @(posedge PCLK); #1;
    PRESET = 0;
    hold_ready = 0;
    n = xfer_count;
    cycles(10);
    check("midreset_fifo_empty", xfer_count - n, 0);

    // Timeout behaviour with the slave never ready.
    hold_ready = 1;
    n = xfer_count;
`ifdef APB_TIMEOUT_EN
    expect_timeout = 1;
    push(0, 32'h20, 32'h0, 4'h0, 3'd0, 1);
    wait_xfer(n);
    t0 = last_xfer_cyc;
    t = 0;
    do begin @(negedge PCLK); t++; end while (!rsp_valid && t < 50);
    check("timeout_cycles", cyc - t0, TIMEOUT);
    wait_drain("timeout");
    expect_timeout = 0;
    @(posedge PCLK); #1;
    hold_ready = 0;
    cycles(10);
`else
    push(0, 32'h20, 32'h0, 4'h0, 3'd0, 0);
    wait_xfer(n);
    seen = 0;
    repeat (100) begin
      @(negedge PCLK);
      if (rsp_valid) seen = 1;
    end
    check("no_timeout_still_wait", seen, 0);
    @(posedge PCLK); #1;
    hold_ready = 0;
    wait_drain("no_timeout");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
